// File: rtl/pid_if.sv
// Sample-request / control-word bundle between the loop front end and pid_controller.
// The master side supplies requests and gains; the slave side is the controller.
interface pid_if #(
  parameter int W  = 16,
  parameter int KW = 16
);
  logic                 sample_valid;
  logic signed [W-1:0]  setpoint;
  logic signed [W-1:0]  feedback;
  logic signed [KW-1:0] kp;
  logic signed [KW-1:0] ki;
  logic signed [KW-1:0] kd;
  logic [1:0]           mode;
  logic                 int_clr;
  logic signed [W-1:0]  ctrl_out;
  logic                 ctrl_valid;
  logic                 busy;
  logic                 sat;
  logic                 overrun;

  modport master (
    output sample_valid, setpoint, feedback, kp, ki, kd, mode, int_clr,
    input  ctrl_out, ctrl_valid, busy, sat, overrun
  );

  modport slave (
    input  sample_valid, setpoint, feedback, kp, ki, kd, mode, int_clr,
    output ctrl_out, ctrl_valid, busy, sat, overrun
  );
endinterface

// File: rtl/pid_controller.sv
// Multi-mode (bypass/P/PI/PID) fixed-point controller with one shared multiplier,
// a clamped integrator and a saturated output, computed over a fixed 5-cycle schedule.
module pid_controller #(
  parameter int W     = 16,
  parameter int KW    = 16,
  parameter int FRAC  = 8,
  parameter int I_LIM = 4096
) (
  input  logic  pid_clk,
  input  logic  rst_n,
  pid_if.slave  bus
);
  localparam int AW = W + KW + 4;
  localparam int PW = W + KW + 2;
  localparam logic signed [W+1:0]  LIM_HI = (W+2)'(I_LIM);
  localparam logic signed [W+1:0]  LIM_LO = -LIM_HI;
  localparam logic signed [AW-1:0] YMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, OUT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q;
  logic signed [W-1:0]  sp_q, fb_q;
  logic signed [KW-1:0] kp_q, ki_q, kd_q;
  logic signed [W:0]    err_q, err_prev_q, integ_q, integ_n_q;
  logic signed [W+1:0]  deriv_q;
  logic signed [AW-1:0] acc_q;
  logic signed [W-1:0]  ctrl_out_q;
  logic                 ctrl_valid_q, sat_q, overrun_q;

  logic                 accept, busy_c;
  logic signed [W:0]    err_c;
  logic signed [W+1:0]  deriv_c, integ_sum_c;
  logic signed [KW-1:0] mul_a;
  logic signed [W+1:0]  mul_b;
  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] sum_c;
  logic [W:0]           y_c;

  // Arithmetic shift (truncation toward -inf) then clip; returns {clipped, value}.
  function automatic logic [W:0] shift_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> FRAC;
    if (s > YMAX) return {1'b1, YMAX[W-1:0]};
    if (s < YMIN) return {1'b1, YMIN[W-1:0]};
    return {1'b0, s[W-1:0]};
  endfunction

  function automatic logic signed [W:0] clamp_int(input logic signed [W+1:0] v);
    if (v > LIM_HI) return LIM_HI[W:0];
    if (v < LIM_LO) return LIM_LO[W:0];
    return v[W:0];
  endfunction

  assign accept      = ((state_q == IDLE) || (state_q == OUT)) && bus.sample_valid;
  assign busy_c      = (state_q == ERR) || (state_q == MP) || (state_q == MI) || (state_q == MD);
  assign err_c       = (W+1)'(sp_q) - (W+1)'(fb_q);
  assign deriv_c     = (W+2)'(err_c) - (W+2)'(err_prev_q);
  assign integ_sum_c = (W+2)'(integ_q) + (W+2)'(err_c);

  // Shared multiplier: gain and operand selected by schedule slot; gated terms multiply by zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MP: begin
        mul_a = kp_q;
        mul_b = (W+2)'(err_q);
      end
      MI: begin
        mul_a = mode_q[1] ? ki_q : '0;
        mul_b = (W+2)'(integ_n_q);
      end
      MD: begin
        mul_a = (mode_q == 2'd3) ? kd_q : '0;
        mul_b = deriv_q;
      end
      default: ;
    endcase
  end

  assign prod_c = PW'(mul_a) * PW'(mul_b);
  assign sum_c  = acc_q + AW'(prod_c);
  assign y_c    = shift_sat(sum_c);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OUT: state_d = bus.sample_valid ? ERR : IDLE;
      ERR:       state_d = MP;
      MP:        state_d = MI;
      MI:        state_d = MD;
      MD:        state_d = OUT;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge pid_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      acc_q        <= '0;
      integ_q      <= '0;
      err_prev_q   <= '0;
      ctrl_out_q   <= '0;
      ctrl_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_valid_q <= 1'b0;
      if (accept) mode_q <= bus.mode;
      if (bus.sample_valid && busy_c) overrun_q <= 1'b1;
      case (state_q)
        ERR:    acc_q <= '0;
        MP, MI: acc_q <= sum_c;
        MD: begin
          acc_q        <= sum_c;
          ctrl_valid_q <= 1'b1;
          if (mode_q == 2'd0) begin
            ctrl_out_q <= sp_q;
            sat_q      <= 1'b0;
          end else begin
            ctrl_out_q <= y_c[W-1:0];
            sat_q      <= y_c[W];
          end
        end
        default: ;
      endcase
      // A clear overrides the commit of an in-flight result.
      if (bus.int_clr) begin
        integ_q    <= '0;
        err_prev_q <= '0;
      end else if (state_q == MD) begin
        err_prev_q <= err_q;
        integ_q    <= mode_q[1] ? integ_n_q : '0;
      end
    end
  end

  always_ff @(posedge pid_clk) begin
    if (accept) begin
      sp_q <= bus.setpoint;
      fb_q <= bus.feedback;
      kp_q <= bus.kp;
      ki_q <= bus.ki;
      kd_q <= bus.kd;
    end
    if (state_q == ERR) begin
      err_q     <= err_c;
      deriv_q   <= deriv_c;
      integ_n_q <= clamp_int(integ_sum_c);
    end
  end

  assign bus.ctrl_out   = ctrl_out_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.busy       = busy_c;
  assign bus.sat        = sat_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/pid_controller.md
# pid_controller

Parametrised, multi-mode PID controller for the amplifier control loop. It runs on the decimated `pid_clk` and accepts one setpoint/feedback sample pair per request. It computes a saturated fixed-point control word through a single shared multiplier over a fixed 5-cycle schedule. It replaces the setpoint pass-through stage: mode 0 reproduces pass-through behaviour, and modes 1–3 add P, PI and PID control with a clamped integrator.

## Interface
- `W`, 16: signed width of setpoint, feedback and `ctrl_out`.
- `KW`, 16: signed width of each gain; gains are Q(KW-FRAC).FRAC.
- `FRAC`, 8: fractional bits; the sum is shifted arithmetic-right by FRAC.
- `I_LIM`, 4096: integrator clamp magnitude, range ±I_LIM; requires 0 < I_LIM < 2^W.
- `pid_clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_valid`  in  1  request; sampled only when `busy`=0.
- `setpoint`  in  W  signed target.
- `feedback`  in  W  signed measured value.
- `kp`, `ki`, `kd`  in  KW each  signed gains, latched at acceptance.
- `mode`  in  2  0 bypass, 1 P, 2 PI, 3 PID; latched at acceptance.
- `int_clr`  in  1  synchronous integrator and previous-error clear.
- `ctrl_out`  out  W  signed control word, held between updates.
- `ctrl_valid`  out  1  one-cycle strobe: `ctrl_out` is new.
- `busy`  out  1  computation in progress.
- `sat`  out  1  last `ctrl_out` was clipped; updated with `ctrl_valid`.
- `overrun`  out  1  sticky; set when `sample_valid`=1 while `busy`=1.

## Operation
- FSM states: IDLE, ERR, MP, MI, MD, OUT. Each state except IDLE lasts exactly one cycle.
- **IDLE/OUT:** `busy`=0. If `sample_valid`=1, latch setpoint, feedback, gains and mode, then go to ERR. Otherwise OUT→IDLE and IDLE stays.
- **ERR:**
  - err = setpoint − feedback, computed in W+1 bits.
  - deriv = err − err_prev, computed in W+2 bits.
  - integ_n = clamp(integ + err, −I_LIM, +I_LIM).
  - acc cleared.
- **MP:** acc += kp·err.
- **MI:** acc += ki·integ_n.
- **MD:** acc += kd·deriv.
  - Accumulator width is W+KW+4, signed.
  - One multiplier is shared across MP, MI and MD.
- **MD→OUT edge:**
  - y = acc >>> FRAC, saturated to [−2^(W−1), 2^(W−1)−1].
  - Register `ctrl_out`=y, `sat`=clip flag, `ctrl_valid`=1.
  - Commit err_prev←err and integ←integ_n.
- **Mode gating:**
  - Mode 0: `ctrl_out`=setpoint and `sat`=0; integ is forced to 0.
  - Mode 1: the ki and kd terms are zeroed; integ is forced to 0.
  - Mode 2: the kd term is zeroed.
  - Mode 3: all terms active.
  - err_prev updates in all modes.
- **Latency:** identical in all modes.
- **Rounding:** none; truncation toward −∞.
- **`int_clr`=1:**
  - integ and err_prev are cleared at the next edge.
  - If the controller is mid-computation, the in-flight result still uses the integ_n/deriv already computed in ERR. The clear then wins over that computation's commit.
- **`overrun`:** requests while `busy`=1 are dropped and set `overrun`. Only reset clears it.
- **Simultaneous events:** a request arriving in OUT is accepted in that same cycle; no idle gap is required.

## Timing
- **Reset values:** state IDLE, all outputs 0, and integ, err_prev and acc all 0.
- **Asynchronous reset:** takes effect immediately and aborts any computation with no `ctrl_valid`.
- **Acceptance:** acceptance at edge E0 gives `ctrl_valid` high in the cycle after edge E4, i.e. 4 cycles later.
- **Busy window:** `busy` is high in ERR, MP, MI and MD.
- **Throughput:** at most one result every 5 cycles, back-to-back via OUT→ERR.
- **Strobe:** `ctrl_valid` is high for exactly 1 cycle per accepted sample. `ctrl_out` is stable until the next strobe.
- **First sample after reset or clear:** deriv equals err, because err_prev = 0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-MI → all outputs 0 immediately; no `ctrl_valid` after release; integ=0.
- **Bypass:** mode 0, setpoint=1234, feedback=−7 → `ctrl_out`=1234 exactly 4 cycles after acceptance, `sat`=0.
- **P only:** mode 1, kp=256, sp=1000, fb=400 → `ctrl_out`=600.
- **P only, negative:** kp=384, sp=0, fb=100 → `ctrl_out`=−150.
- **PI clamp:** mode 2, kp=0, ki=256, I_LIM=1000, err=600 for three samples → 600, 1000, 1000.
- **PI clear:** after the clamp sequence, pulse `int_clr`; next sample with err=600 → 600.
- **Derivative:** mode 3, kp=ki=0, kd=256, errors 100 then 300 → 100 then 200.
- **Saturation:** mode 1, kp=25600, err=1000 → `ctrl_out`=32767, `sat`=1.
- **Saturation, negative:** err=−1000 → `ctrl_out`=−32768, `sat`=1.
- **Overrun/throughput:** `sample_valid` held high continuously → one `ctrl_valid` every 5 cycles and `overrun`=1 from the first busy-cycle request. A pulse arriving in MI is dropped and does not change the results.
